// File: rtl/pc_source_ctrl.sv
// PC-source sequencer: selects the next-PC source for normal updates and runs the
// exception entry sequence (save EPC, fetch the handler byte, jump to the handler).
module pc_source_ctrl #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter logic [31:0] VEC_DIVZERO  = 32'd253,
    parameter logic [31:0] VEC_OPCODE   = 32'd254,
    parameter logic [31:0] VEC_OVERFLOW = 32'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pc_advance,
    input  logic        branch_taken,
    input  logic        is_jump,
    input  logic        exc_opcode,
    input  logic        exc_divzero,
    input  logic        exc_overflow,
    input  logic [31:0] pc_current,
    input  logic [31:0] mem_data_in,
    output logic [3:0]  pcsource_sel,
    output logic        pc_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] exception_target,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LOAD,
        ST_JUMP
    } state_t;

    localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
    localparam logic [1:0] CAUSE_DIVZERO  = 2'b11;

    localparam logic [3:0] SEL_ALU    = 4'd0;
    localparam logic [3:0] SEL_ALUOUT = 4'd1;
    localparam logic [3:0] SEL_JUMP   = 4'd2;
    localparam logic [3:0] SEL_EXC    = 4'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic        exc_any;
    logic [1:0]  cause_next;
    logic [31:0] vector_addr;

    // Only the low byte of the vector table entry is meaningful.
    logic unused_mem_bits;
    assign unused_mem_bits = ^mem_data_in[31:8];

    assign exc_any = exc_opcode | exc_divzero | exc_overflow;
    assign busy    = (state != ST_IDLE);

    always_comb begin
        cause_next = CAUSE_OVERFLOW;
        if (exc_opcode) begin
            cause_next = CAUSE_OPCODE;
        end else if (exc_divzero) begin
            cause_next = CAUSE_DIVZERO;
        end
    end

    always_comb begin
        vector_addr = 32'd0;
        case (exc_cause)
            CAUSE_OPCODE:   vector_addr = VEC_OPCODE;
            CAUSE_OVERFLOW: vector_addr = VEC_OVERFLOW;
            CAUSE_DIVZERO:  vector_addr = VEC_DIVZERO;
            default:        vector_addr = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            wait_cnt         <= 4'd0;
            epc              <= 32'd0;
            exception_target <= 32'd0;
            exc_cause        <= 2'b00;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (exc_any) begin
                        exc_cause <= cause_next;
                        epc       <= pc_current - 32'd4;
                    end
                end
                ST_REQ:  wait_cnt <= WAIT_LOAD;
                ST_WAIT: wait_cnt <= wait_cnt - 4'd1;
                ST_LOAD: exception_target <= {24'b0, mem_data_in[7:0]};
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_next   = state;
        pcsource_sel = SEL_ALU;
        pc_write     = 1'b0;
        mem_read     = 1'b0;
        mem_addr     = 32'd0;
        case (state)
            ST_IDLE: begin
                if (exc_any) begin
                    state_next = ST_REQ;
                end else begin
                    pc_write = pc_advance | branch_taken | is_jump;
                    if (is_jump) begin
                        pcsource_sel = SEL_JUMP;
                    end else if (branch_taken) begin
                        pcsource_sel = SEL_ALUOUT;
                    end
                end
            end
            ST_REQ: begin
                mem_read   = 1'b1;
                mem_addr   = vector_addr;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Leaving on a count of 1 makes WAIT last exactly MEM_LATENCY cycles.
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: state_next = ST_JUMP;
            ST_JUMP: begin
                pc_write     = 1'b1;
                pcsource_sel = SEL_EXC;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
